// File: rtl/btb_pmem_pkg.sv
// Shared types for the BTB physical-memory responder.
// States of the request FSM, the captured operation kind, and line geometry.
// No logic lives here.
package btb_pmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  // 32-byte lines: byte-offset bits below the line index
  localparam int LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/btb_pmem_line_array.sv
// Backing store of lines with per-line valid bits.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none; the caller owns sequencing.
module btb_pmem_line_array #(
  parameter int LINE_WIDTH = 256,
  parameter int INDEX_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] widx,
  input  logic [LINE_WIDTH-1:0] wdata,
  input  logic [INDEX_BITS-1:0] ridx,
  output logic [LINE_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  logic [LINE_WIDTH-1:0]      mem [2**INDEX_BITS];
  logic [2**INDEX_BITS-1:0]   valid;

  // Line storage: contents survive reset, only the valid bits are cleared
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  // Valid bits: cleared by reset, set by any write to the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= '0;
    else if (we) valid[widx] <= 1'b1;
  end

  assign rdata  = mem[ridx];
  assign rvalid = valid[ridx];

endmodule

// File: rtl/btb_pmem_responder.sv
// Line-granular pmem responder for the BTB cache miss path.
// Latency: pmem_resp pulses LATENCY cycles after the request is sampled.
// Backpressure: one transaction in flight; requests are ignored while busy.
module btb_pmem_responder
  import btb_pmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int INDEX_BITS = 5,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic                  pmem_resp,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  busy,
  output logic                  protocol_err
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  state_t                  state;
  logic [3:0]              count;
  op_t                     op;
  logic [INDEX_BITS-1:0]   idx;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic [INDEX_BITS-1:0]   addr_idx;
  logic                    req;
  logic                    last_busy;
  logic                    array_we;
  logic [LINE_WIDTH-1:0]   line;
  logic                    line_valid;
  logic                    unused_addr;

  // Bits outside the line index alias; they are deliberately dropped
  assign addr_idx    = pmem_address[INDEX_BITS+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
  assign unused_addr = ^{pmem_address[ADDR_WIDTH-1:INDEX_BITS+LINE_OFFSET_BITS],
                         pmem_address[LINE_OFFSET_BITS-1:0]};
  assign req         = pmem_read | pmem_write;

  // Final countdown cycle: the edge ending it enters RESP
  assign last_busy = (state == BUSY) && (count == 4'd0);
  assign array_we  = last_busy && (op == OP_WRITE);

  assign pmem_resp = (state == RESP);
  assign busy      = (state != IDLE);

  btb_pmem_line_array #(
    .LINE_WIDTH (LINE_WIDTH),
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (array_we),
    .widx   (idx),
    .wdata  (wdata_q),
    .ridx   (idx),
    .rdata  (line),
    .rvalid (line_valid)
  );

  // Capture the request when accepted; read+write together counts as a write
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      idx     <= addr_idx;
      op      <= pmem_write ? OP_WRITE : OP_READ;
      wdata_q <= pmem_wdata;
    end
  end

  // Request FSM with latency countdown, read-data register and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= 4'd0;
      pmem_rdata   <= '0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= BUSY;
            count <= LAT_LOAD;
            if (pmem_read && pmem_write) protocol_err <= 1'b1;
          end
        end
        BUSY: begin
          // Initiator must hold its request until the response
          if (!req) protocol_err <= 1'b1;
          if (count == 4'd0) begin
            state <= RESP;
            if (op == OP_READ) pmem_rdata <= line_valid ? line : '0;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_pmem_responder.sv
// Bench for btb_pmem_responder: three instances (LATENCY 4, 1, 15) checked
// every cycle against a transaction-timed model, plus directed literal checks.
module tb_btb_pmem_responder;

  localparam logic [255:0] PAT_A = {16'hDEAD,
    224'h0123_4567_89AB_CDEF_0011_2233_4455_6677_8899_AABB_CCDD_EEFF_1234_5678, 16'hBEEF};
  localparam logic [255:0] PAT_B = {8{32'hA5A5_0F0F}};
  localparam logic [255:0] PAT_C = {4{64'h1357_9BDF_2468_ACE0}};

  logic         clk = 1'b0;
  logic         rst;
  logic         rd    [3];
  logic         wr    [3];
  logic [31:0]  addr  [3];
  logic [255:0] wd    [3];
  logic         resp  [3];
  logic [255:0] rdata [3];
  logic         bsy   [3];
  logic         perr  [3];

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int cyc    = 0;
  bit started = 0;

  always #5 clk = ~clk;

  btb_pmem_responder #(.LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wd[0]), .pmem_resp(resp[0]),
    .pmem_rdata(rdata[0]), .busy(bsy[0]), .protocol_err(perr[0]));
  btb_pmem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wd[1]), .pmem_resp(resp[1]),
    .pmem_rdata(rdata[1]), .busy(bsy[1]), .protocol_err(perr[1]));
  btb_pmem_responder #(.LATENCY(15)) dut2 (
    .clk(clk), .rst(rst), .pmem_read(rd[2]), .pmem_write(wr[2]),
    .pmem_address(addr[2]), .pmem_wdata(wd[2]), .pmem_resp(resp[2]),
    .pmem_rdata(rdata[2]), .busy(bsy[2]), .protocol_err(perr[2]));

  function automatic int lat(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 15;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end else begin
      passes++;
    end
  endtask

  // Model: a transaction sampled at edge S responds in the cycle after edge
  // S+L, commits its effect on that edge, and frees the port one edge later.
  bit           m_pend  [3];
  int           m_samp  [3];
  bit           m_write [3];
  int           m_idx   [3];
  logic [255:0] m_wd    [3];
  logic [255:0] m_mem   [3][32];
  bit           m_val   [3][32];
  logic [255:0] m_rdata [3];
  bit           m_perr  [3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_pend[k]  <= 1'b0;
        m_rdata[k] <= '0;
        m_perr[k]  <= 1'b0;
        for (int i = 0; i < 32; i++) m_val[k][i] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!m_pend[k]) begin
          if (rd[k] || wr[k]) begin
            m_pend[k]  <= 1'b1;
            m_samp[k]  <= cyc + 1;
            m_write[k] <= wr[k];
            m_idx[k]   <= int'(addr[k] / 32) % 32;
            m_wd[k]    <= wd[k];
            if (rd[k] && wr[k]) m_perr[k] <= 1'b1;
          end
        end else begin
          if (cyc + 1 <= m_samp[k] + lat(k) && !rd[k] && !wr[k]) m_perr[k] <= 1'b1;
          if (cyc + 1 == m_samp[k] + lat(k)) begin
            if (m_write[k]) begin
              m_mem[k][m_idx[k]] <= m_wd[k];
              m_val[k][m_idx[k]] <= 1'b1;
            end else begin
              m_rdata[k] <= m_val[k][m_idx[k]] ? m_mem[k][m_idx[k]] : '0;
            end
          end
          if (cyc + 1 == m_samp[k] + lat(k) + 1) m_pend[k] <= 1'b0;
        end
      end
    end
  end

  // Per-cycle compare of every instance against the model
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("resp%0d", k), 256'(resp[k]), 256'(m_pend[k] && (cyc == m_samp[k] + lat(k))));
        chk($sformatf("busy%0d", k), 256'(bsy[k]), 256'(m_pend[k]));
        chk($sformatf("perr%0d", k), 256'(perr[k]), 256'(m_perr[k]));
        chk($sformatf("rdata%0d", k), rdata[k], m_rdata[k]);
      end
    end
  end

  // One request, held until pmem_resp; optional live-input change mid-flight
  task automatic txn(input int k, input bit r, input bit w, input logic [31:0] a,
                     input logic [255:0] d, input int chg_at, input logic [31:0] a2,
                     input logic [255:0] d2, output int lat_seen, output int resp_cyc,
                     output int busy_n, output logic [255:0] rdat);
    int n;
    bit got;
    n = 0; got = 0; lat_seen = -1; resp_cyc = -1; busy_n = 0; rdat = '0;
    @(negedge clk); #1;
    rd[k] = r; wr[k] = w; addr[k] = a; wd[k] = d;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bsy[k]) busy_n++;
      if (resp[k]) begin
        got = 1; lat_seen = n - 1; resp_cyc = cyc; rdat = rdata[k];
      end else if (n == chg_at) begin
        #1; addr[k] = a2; wd[k] = d2;
      end
    end
    #1; rd[k] = 1'b0; wr[k] = 1'b0;
    chk($sformatf("resp_seen%0d", k), 256'(got), 256'(1));
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int l, rc, rc2, bn, nresp, nb;
    logic [255:0] d;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wd[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_resp", 256'(resp[0]), 256'(0));
    chk("reset_busy", 256'(bsy[0]), 256'(0));
    chk("reset_perr", 256'(perr[0]), 256'(0));
    chk("reset_rdata", rdata[0], 256'(0));
    #1 rst = 1'b0;
    started = 1;

    // Never-written line: latency 4, zero data, busy over countdown plus resp cycle
    txn(0, 1, 0, 32'h40, '0, 0, '0, '0, l, rc, bn, d);
    chk("unwritten_latency", 256'(l), 256'(4));
    chk("unwritten_rdata", d, 256'(0));
    chk("unwritten_busy_cycles", 256'(bn), 256'(5));

    // Write then read, including an aliased address of index 1
    txn(0, 0, 1, 32'h20, PAT_A, 0, '0, '0, l, rc, bn, d);
    chk("write_no_rdata_change", d, 256'(0));
    txn(0, 1, 0, 32'h20, '0, 0, '0, '0, l, rc, bn, d);
    chk("raw_rdata", d, PAT_A);
    txn(0, 1, 0, 32'h420, '0, 0, '0, '0, l, rc, bn, d);
    chk("alias_rdata", d, PAT_A);

    // Live address/data changed mid-BUSY must not leak into the write
    txn(0, 0, 1, 32'h60, PAT_B, 2, 32'hA0, PAT_C, l, rc, bn, d);
    txn(0, 1, 0, 32'h60, '0, 0, '0, '0, l, rc, bn, d);
    chk("captured_data_used", d, PAT_B);
    txn(0, 1, 0, 32'hA0, '0, 0, '0, '0, l, rc, bn, d);
    chk("live_addr_untouched", d, 256'(0));
    chk("no_err_so_far", 256'(perr[0]), 256'(0));

    // Read and write together: acts as a write, sticky error
    txn(0, 1, 1, 32'hC0, PAT_C, 0, '0, '0, l, rc, bn, d);
    chk("both_err_set", 256'(perr[0]), 256'(1));
    txn(0, 1, 0, 32'hC0, '0, 0, '0, '0, l, rc, bn, d);
    chk("both_acts_as_write", d, PAT_C);
    chk("both_err_sticky", 256'(perr[0]), 256'(1));
    do_reset();
    chk("err_cleared_by_reset", 256'(perr[0]), 256'(0));

    // Request dropped in BUSY: error, but the read still completes
    @(negedge clk); #1;
    rd[0] = 1'b1; addr[0] = 32'h40;
    @(negedge clk); #1 rd[0] = 1'b0;
    nb = 0;
    while (bsy[0] && nb < 40) begin
      @(negedge clk); nb++;
    end
    chk("drop_busy_ends", 256'(bsy[0]), 256'(0));
    chk("drop_err_set", 256'(perr[0]), 256'(1));
    do_reset();

    // Reset two cycles into a write aborts it
    @(negedge clk); #1;
    wr[0] = 1'b1; addr[0] = 32'h80; wd[0] = PAT_C;
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b1; wr[0] = 1'b0;
    nresp = 0;
    repeat (3) begin @(negedge clk); if (resp[0]) nresp++; end
    #1 rst = 1'b0;
    repeat (8) begin @(negedge clk); if (resp[0]) nresp++; end
    chk("reset_abort_no_resp", 256'(nresp), 256'(0));
    txn(0, 1, 0, 32'h80, '0, 0, '0, '0, l, rc, bn, d);
    chk("reset_abort_line_empty", d, 256'(0));

    // Latency sweep: back-to-back, request re-raised in the cycle after resp
    txn(1, 0, 1, 32'hE0, PAT_B, 0, '0, '0, l, rc, bn, d);
    txn(1, 1, 0, 32'hE0, '0, 0, '0, '0, l, rc, bn, d);
    chk("lat1_latency", 256'(l), 256'(1));
    chk("lat1_rdata", d, PAT_B);
    txn(1, 1, 0, 32'hE0, '0, 0, '0, '0, l, rc2, bn, d);
    chk("lat1_spacing", 256'(rc2 - rc), 256'(3));
    txn(2, 1, 0, 32'h0, '0, 0, '0, '0, l, rc, bn, d);
    chk("lat15_latency", 256'(l), 256'(15));
    txn(2, 1, 0, 32'h0, '0, 0, '0, '0, l, rc2, bn, d);
    chk("lat15_spacing", 256'(rc2 - rc), 256'(17));

    repeat (3) @(negedge clk);
    started = 0;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
